ysyx_23060184_fetch_pc_ctrl: RTL and testbench

//  PC generator and fetch-request controller directly upstream of the instruction-memory AXI fetch unit.

---
 rtl/ysyx_23060184_fetch_pc_ctrl_if.sv | 27 ++
 rtl/ysyx_23060184_fetch_pc_ctrl.sv | 111 +++++++++++
 tb/tb_ysyx_23060184_fetch_pc_ctrl.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/ysyx_23060184_fetch_pc_ctrl_if.sv
// Fetch-side bundle between the PC controller, InstMem and decode.
// master = PC controller, slave = the surrounding memory/decode/backend.
interface ysyx_23060184_fetch_pc_ctrl_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  Iready;
  logic                  Ivalid;
  logic                  Dready;
  logic                  stall;
  logic                  redirect_valid;
  logic [DATA_WIDTH-1:0] redirect_pc;
  logic                  Pvalid;
  logic [DATA_WIDTH-1:0] pc;
  logic [DATA_WIDTH-1:0] inst_pc;
  logic                  inst_kill;
  logic [31:0]           inst_count;

  modport master (
    input  Iready, Ivalid, Dready, stall, redirect_valid, redirect_pc,
    output Pvalid, pc, inst_pc, inst_kill, inst_count
  );

  modport slave (
    output Iready, Ivalid, Dready, stall, redirect_valid, redirect_pc,
    input  Pvalid, pc, inst_pc, inst_kill, inst_count
  );
endinterface

// File: rtl/ysyx_23060184_fetch_pc_ctrl.sv
// PC generator and fetch-request controller feeding the InstMem AXI fetch unit.
// One fetch outstanding at most; redirects arriving while a fetch is in flight
// are parked in pend_pc and the returning instruction is flagged stale.
module ysyx_23060184_fetch_pc_ctrl #(
  parameter int                    DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_PC   = 32'h8000_0000,
  parameter int                    INST_BYTES = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  ysyx_23060184_fetch_pc_ctrl_if.master fb
);

  localparam logic [1:0] ST_BOOT = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_WAIT = 2'd2;
  localparam logic [1:0] ST_HOLD = 2'd3;

  logic [1:0]            state_q, state_d;
  logic [DATA_WIDTH-1:0] pc_q, pc_d;
  logic [DATA_WIDTH-1:0] inst_pc_q, inst_pc_d;
  logic                  inst_kill_q, inst_kill_d;
  logic [31:0]           inst_count_q, inst_count_d;
  logic                  pend_valid_q, pend_valid_d;
  logic [DATA_WIDTH-1:0] pend_pc_q, pend_pc_d;
  logic                  done;

  // Next-state and datapath decisions for the fetch sequencer
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    inst_pc_d    = inst_pc_q;
    inst_kill_d  = inst_kill_q;
    inst_count_d = inst_count_q;
    pend_valid_d = pend_valid_q;
    pend_pc_d    = pend_pc_q;
    done         = (state_q == ST_WAIT) && fb.Ivalid && fb.Dready;

    case (state_q)
      ST_BOOT: begin
        state_d = fb.stall ? ST_HOLD : ST_REQ;
        if (fb.redirect_valid) pc_d = fb.redirect_pc;
      end
      ST_REQ: begin
        if (fb.Iready) begin
          // Request accepted; a same-edge redirect targets the fetch just
          // issued, so it is parked exactly as if it arrived during WAIT.
          state_d   = ST_WAIT;
          inst_pc_d = pc_q;
          if (fb.redirect_valid) begin
            pend_valid_d = 1'b1;
            pend_pc_d    = fb.redirect_pc;
            inst_kill_d  = 1'b1;
          end
        end else begin
          if (fb.redirect_valid) pc_d = fb.redirect_pc;
          if (fb.stall) state_d = ST_HOLD;
        end
      end
      ST_WAIT: begin
        if (done) begin
          if (!inst_kill_q) inst_count_d = inst_count_q + 32'd1;
          // A redirect on the completion edge belongs to the delivered
          // instruction, so it wins over any parked target and kills nothing.
          if (fb.redirect_valid)  pc_d = fb.redirect_pc;
          else if (pend_valid_q)  pc_d = pend_pc_q;
          else                    pc_d = pc_q + DATA_WIDTH'(INST_BYTES);
          pend_valid_d = 1'b0;
          inst_kill_d  = 1'b0;
          state_d      = fb.stall ? ST_HOLD : ST_REQ;
        end else if (fb.redirect_valid) begin
          pend_valid_d = 1'b1;
          pend_pc_d    = fb.redirect_pc;
          inst_kill_d  = 1'b1;
        end
      end
      default: begin
        if (fb.redirect_valid) pc_d = fb.redirect_pc;
        if (!fb.stall) state_d = ST_REQ;
      end
    endcase
  end

  // State registers; reset abandons any outstanding fetch immediately
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_BOOT;
      pc_q         <= RESET_PC;
      inst_pc_q    <= '0;
      inst_kill_q  <= 1'b0;
      inst_count_q <= '0;
      pend_valid_q <= 1'b0;
      pend_pc_q    <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      inst_pc_q    <= inst_pc_d;
      inst_kill_q  <= inst_kill_d;
      inst_count_q <= inst_count_d;
      pend_valid_q <= pend_valid_d;
      pend_pc_q    <= pend_pc_d;
    end
  end

  assign fb.Pvalid     = (state_q == ST_REQ);
  assign fb.pc         = pc_q;
  assign fb.inst_pc    = inst_pc_q;
  assign fb.inst_kill  = inst_kill_q;
  assign fb.inst_count = inst_count_q;

endmodule

// File: tb/tb_ysyx_23060184_fetch_pc_ctrl.sv
// Self-checking bench for the fetch PC controller: directed scenarios followed
// by randomized traffic, all compared against a transaction-level model.
module tb_ysyx_23060184_fetch_pc_ctrl;

  localparam logic [31:0] RST_PC = 32'h8000_0000;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  ysyx_23060184_fetch_pc_ctrl_if #(.DATA_WIDTH(32)) bus ();

  ysyx_23060184_fetch_pc_ctrl #(
    .DATA_WIDTH(32),
    .RESET_PC  (32'h8000_0000),
    .INST_BYTES(4)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .fb   (bus)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: a fetch is either idle-requesting, held by stall,
  // in the boot cycle, or outstanding; redirects are tracked as a pending target.
  bit          m_boot, m_busy, m_hold, m_kill, m_pend;
  logic [31:0] m_pc, m_ipc, m_ppc, m_cnt;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_boot = 1; m_busy = 0; m_hold = 0; m_kill = 0; m_pend = 0;
    m_pc = RST_PC; m_ipc = 0; m_ppc = 0; m_cnt = 0;
  endtask

  task automatic model_clock(input bit ir, input bit iv, input bit dr, input bit st,
                             input bit rv, input logic [31:0] rpc);
    if (m_boot) begin
      m_boot = 0;
      m_hold = st;
      if (rv) m_pc = rpc;
    end else if (!m_busy) begin
      if (!m_hold && ir) begin
        m_busy = 1;
        m_ipc  = m_pc;
        if (rv) begin m_pend = 1; m_ppc = rpc; m_kill = 1; end
      end else begin
        if (rv) m_pc = rpc;
        m_hold = st;
      end
    end else if (iv && dr) begin
      if (!m_kill) m_cnt = m_cnt + 1;
      m_pc   = rv ? rpc : (m_pend ? m_ppc : m_pc + 32'd4);
      m_pend = 0; m_kill = 0; m_busy = 0;
      m_hold = st;
    end else if (rv) begin
      m_pend = 1; m_ppc = rpc; m_kill = 1;
    end
  endtask

  task automatic check_outputs();
    check_val("Pvalid",     {31'd0, bus.Pvalid},    {31'd0, (!m_boot && !m_busy && !m_hold)});
    check_val("pc",         bus.pc,                 m_pc);
    check_val("inst_pc",    bus.inst_pc,            m_ipc);
    check_val("inst_kill",  {31'd0, bus.inst_kill}, {31'd0, m_kill});
    check_val("inst_count", bus.inst_count,         m_cnt);
  endtask

  // Called at a negedge: drive, check pre-edge outputs, clock, update model.
  task automatic step(input bit ir, input bit iv, input bit dr, input bit st,
                      input bit rv, input logic [31:0] rpc);
    bus.Iready = ir; bus.Ivalid = iv; bus.Dready = dr; bus.stall = st;
    bus.redirect_valid = rv; bus.redirect_pc = rpc;
    #1;
    check_outputs();
    @(posedge clk);
    model_clock(ir, iv, dr, st, rv, rpc);
    @(negedge clk);
  endtask

  task automatic check_reset_values(input string tag);
    check_val({tag, "_pc"},     bus.pc,                 RST_PC);
    check_val({tag, "_pvalid"}, {31'd0, bus.Pvalid},    32'd0);
    check_val({tag, "_kill"},   {31'd0, bus.inst_kill}, 32'd0);
    check_val({tag, "_count"},  bus.inst_count,         32'd0);
    check_val({tag, "_ipc"},    bus.inst_pc,            32'd0);
  endtask

  // Asserts reset asynchronously between edges and checks its immediate effect.
  task automatic async_reset(input string tag);
    #2;
    reset = 1'b1;
    #1;
    check_reset_values(tag);
    model_reset();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    bus.Iready = 0; bus.Ivalid = 0; bus.Dready = 0; bus.stall = 0;
    bus.redirect_valid = 0; bus.redirect_pc = 0;
    model_reset();
    repeat (2) @(negedge clk);
    #1;
    check_reset_values("reset");
    @(negedge clk);
    reset = 1'b0;

    // T1: boot, first fetch, completion
    step(1, 0, 0, 0, 0, 0);
    check_val("t1_pvalid", {31'd0, bus.Pvalid}, 32'd1);
    check_val("t1_pc", bus.pc, 32'h8000_0000);
    step(1, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    step(0, 1, 1, 0, 0, 0);
    check_val("t1_pc_next", bus.pc, 32'h8000_0004);
    check_val("t1_count", bus.inst_count, 32'd1);

    // T2: back-to-back fetches with 2-cycle memory latency
    for (int i = 0; i < 3; i++) begin
      step(1, 0, 0, 0, 0, 0);
      step(0, 0, 1, 0, 0, 0);
      step(0, 1, 1, 0, 0, 0);
    end
    check_val("t2_pc", bus.pc, 32'h8000_0010);

    // PC wrap: redirect in REQ to the last word, then sequential step
    step(0, 0, 0, 0, 1, 32'hFFFF_FFFC);
    step(1, 0, 0, 0, 0, 0);
    step(0, 1, 1, 0, 0, 0);
    check_val("wrap_pc", bus.pc, 32'h0000_0000);

    // T3: redirect during WAIT kills the returning instruction
    step(1, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1, 32'h8000_0100);
    check_val("t3_kill", {31'd0, bus.inst_kill}, 32'd1);
    step(0, 0, 0, 0, 0, 0);
    step(0, 1, 1, 0, 0, 0);
    check_val("t3_pc", bus.pc, 32'h8000_0100);
    check_val("t3_count", bus.inst_count, 32'd5);

    // T4: redirect on completion edge is not a kill
    step(1, 0, 0, 0, 0, 0);
    step(0, 1, 1, 0, 1, 32'h8000_0200);
    check_val("t4_pc", bus.pc, 32'h8000_0200);
    check_val("t4_count", bus.inst_count, 32'd6);

    // T5: stall across WAIT, completion, then HOLD until stall drops
    step(1, 0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 0, 0);
    step(0, 0, 0, 1, 0, 0);
    step(0, 1, 1, 1, 0, 0);
    step(1, 0, 0, 1, 0, 0);
    step(1, 0, 0, 1, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    check_val("t5_pvalid", {31'd0, bus.Pvalid}, 32'd1);

    // T6: reset mid-WAIT with a pending redirect
    step(1, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1, 32'h8000_0300);
    async_reset("t6");
    step(1, 0, 0, 0, 0, 0);
    check_val("t6_boot_pc", bus.pc, 32'h8000_0000);

    // Randomized traffic against the model
    for (int n = 0; n < 4000; n++) begin
      logic [31:0] rpc;
      rpc = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFC : ($urandom & 32'hFFFF_FFFC);
      step($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
           $urandom_range(0, 3) != 0, $urandom_range(0, 3) == 0,
           $urandom_range(0, 7) == 0, rpc);
      if (n % 997 == 996) async_reset("rnd_reset");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
